// File: rtl/mode_sequencer.sv
// mode_sequencer: front-panel mode stepper with debounced forward/back
// buttons, wrap-around mode index, one-hot run enables and idle timeout.
//
// Parameters:
//   NUM_MODES        modes including IDLE (mode 0), 2..16
//   DEBOUNCE_CYCLES  stable samples needed to accept a level change, >= 1
//   TIMEOUT_CYCLES   idle-return delay in cycles, 0 disables it
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous active-low reset
//   SW_MODE       raw forward button, active high, asynchronous
//   SW_BACK       raw back button, active high, asynchronous
//   MODE_LOCK     discards accepted presses and freezes the timeout
//   MODE_RUN      one-hot run enables, bit i-1 set in mode i
//   MODE_INDEX    current mode number
//   MODE_CHANGED  one-cycle pulse when MODE_INDEX takes a new value
//   TIMEOUT_FLAG  one-cycle pulse on a timeout-forced return to IDLE
module mode_sequencer #(
   parameter int NUM_MODES       = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 1000,
   localparam int MW             = $clog2(NUM_MODES)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 SW_MODE,
   input  logic                 SW_BACK,
   input  logic                 MODE_LOCK,
   output logic [NUM_MODES-2:0] MODE_RUN,
   output logic [MW-1:0]        MODE_INDEX,
   output logic                 MODE_CHANGED,
   output logic                 TIMEOUT_FLAG
);

   // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
   localparam int DW =
      (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

   // Timeout counter only has to reach TIMEOUT_CYCLES-1.
   localparam int TW =
      (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_LAST =
      TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit T_EN = (TIMEOUT_CYCLES != 0);

   localparam logic [MW-1:0] M_LAST = MW'(NUM_MODES - 1);
   localparam logic [MW-1:0] M_IDLE = '0;

   localparam int B_FWD  = 0;
   localparam int B_BACK = 1;

   // ---------------------------------------------------------------
   // Button synchronisers and debouncers
   // ---------------------------------------------------------------
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    db;
   logic [DW-1:0] db_cnt [2];
   logic [1:0]    flip;
   logic [1:0]    rise;

   // flip: this edge delivers the last differing sample, so the
   // debounced level changes now.  rise: that change is 0->1.
   always_comb begin
      flip = '0;
      rise = '0;
      for (int b = 0; b < 2; b++) begin
         flip[b] = (sync2[b] != db[b]) && (db_cnt[b] == D_LAST);
         rise[b] = flip[b] && !db[b];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         for (int b = 0; b < 2; b++) begin
            db_cnt[b] <= '0;
         end
      end else begin
         sync1 <= {SW_BACK, SW_MODE};
         sync2 <= sync1;
         for (int b = 0; b < 2; b++) begin
            if (sync2[b] == db[b]) begin
               db_cnt[b] <= '0;
            end else if (flip[b]) begin
               db[b]     <= sync2[b];
               db_cnt[b] <= '0;
            end else begin
               db_cnt[b] <= db_cnt[b] + DW'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Mode state machine
   // ---------------------------------------------------------------
   logic [MW-1:0] mode;
   logic [MW-1:0] mode_nxt;
   logic [TW-1:0] tcnt;
   logic [TW-1:0] tcnt_nxt;
   logic          changed_nxt;
   logic          tflag_nxt;

   logic any_press;
   logic step_fwd;
   logic step_back;
   logic tick_en;
   logic expire;

   // State register
   always_ff @(posedge clock) begin
      if (!reset) begin
         mode         <= M_IDLE;
         tcnt         <= '0;
         MODE_CHANGED <= 1'b0;
         TIMEOUT_FLAG <= 1'b0;
      end else begin
         mode         <= mode_nxt;
         tcnt         <= tcnt_nxt;
         MODE_CHANGED <= changed_nxt;
         TIMEOUT_FLAG <= tflag_nxt;
      end
   end

   // Next-state logic.  A press on both buttons at once is still an
   // accepted press: it restarts the timeout but leaves the mode.
   // Any accepted press also outranks a timeout on the same edge.
   always_comb begin
      mode_nxt    = mode;
      tcnt_nxt    = tcnt;
      tflag_nxt   = 1'b0;
      changed_nxt = 1'b0;

      any_press = |rise;
      step_fwd  = rise[B_FWD] && !rise[B_BACK] && !MODE_LOCK;
      step_back = rise[B_BACK] && !rise[B_FWD] && !MODE_LOCK;
      tick_en   = T_EN && (mode != M_IDLE) && !MODE_LOCK;
      expire    = tick_en && (tcnt == T_LAST) && !any_press;

      unique case (1'b1)
         step_fwd: begin
            if (mode == M_LAST) mode_nxt = M_IDLE;
            else                mode_nxt = mode + MW'(1);
         end
         step_back: begin
            if (mode == M_IDLE) mode_nxt = M_LAST;
            else                mode_nxt = mode - MW'(1);
         end
         expire: begin
            mode_nxt  = M_IDLE;
            tflag_nxt = 1'b1;
         end
         default: begin
            mode_nxt = mode;
         end
      endcase

      changed_nxt = (mode_nxt != mode);

      if (any_press || changed_nxt) begin
         tcnt_nxt = '0;
      end else if (tick_en) begin
         tcnt_nxt = tcnt + TW'(1);
      end
   end

   // Output decode, purely from the mode register
   always_comb begin
      MODE_INDEX = mode;
      MODE_RUN   = '0;
      for (int i = 1; i < NUM_MODES; i++) begin
         MODE_RUN[i-1] = (mode == MW'(i));
      end
   end

endmodule

// File: doc/mode_sequencer.md
# mode_sequencer

Parametrised mode-select sequencer for the digital clock's front panel, generalising the fixed four-state mode FSM. It debounces the mode and back buttons, steps a mode index through NUM_MODES positions with wrap-around in both directions, and drives one-hot run enables to the time-set, alarm-set, stopwatch and any further functional blocks. A held button advances exactly once, and an inactivity timeout returns the panel to idle.

## Interface
- NUM_MODES, 4: total modes including IDLE (mode 0); legal range 2..16.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to accept a level change; minimum 1.
- TIMEOUT_CYCLES, 1000: cycles of inactivity in a non-idle mode before forced return to IDLE; 0 disables the timeout.
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- SW_MODE  input  1  raw, asynchronous forward-mode button, active high.
- SW_BACK  input  1  raw, asynchronous back-mode button, active high.
- MODE_LOCK  input  1  synchronous; when high, accepted presses are ignored and the timeout counter holds.
- MODE_RUN  output  NUM_MODES-1  one-hot run enables; bit i-1 high when in mode i; all zero in IDLE.
- MODE_INDEX  output  clog2(NUM_MODES)  current mode number.
- MODE_CHANGED  output  1  one-cycle pulse on the cycle MODE_INDEX takes a new value.
- TIMEOUT_FLAG  output  1  one-cycle pulse when a timeout forces the return to IDLE.

## Operation
- Synchronisation: each button passes through a 2-flop synchroniser (s1→s2). Synchroniser flops reset to 0.
- Debounce, per button: a counter runs while s2 differs from the debounced level db and clears when s2 equals db. On the DEBOUNCE_CYCLES-th consecutive differing sample, db takes the value of s2 and the counter clears. A pulse shorter than DEBOUNCE_CYCLES samples is discarded.
- A press is accepted on the edge where db goes 0→1. The 1→0 transition produces no action. A held button therefore yields one press only.
- Mode update, all registered:
  - Forward press: mode = mode+1, wrapping from NUM_MODES-1 to 0.
  - Back press: mode = mode-1, wrapping from 0 to NUM_MODES-1.
  - Forward and back accepted on the same edge: no change, no MODE_CHANGED.
  - MODE_LOCK high: presses are still debounced but discarded; mode holds.
- Timeout:
  - The counter clears on reset, on any mode change, and on any accepted press (locked presses included).
  - The counter increments each cycle while mode≠0, MODE_LOCK is low and TIMEOUT_CYCLES≠0. It stays at 0 in IDLE.
  - When the count reaches TIMEOUT_CYCLES, mode goes to 0, MODE_CHANGED and TIMEOUT_FLAG pulse, and the counter clears.
  - A press accepted on the same edge as the timeout wins: normal step, no TIMEOUT_FLAG.
- MODE_RUN and MODE_INDEX are decoded from the mode register. No combinational path exists from the inputs to the outputs.

## Timing
- Reset values: mode=0, MODE_RUN=0, MODE_INDEX=0, MODE_CHANGED=0, TIMEOUT_FLAG=0. All synchroniser, debounce and timeout state is 0.
- Reset asserted mid-debounce or mid-timeout: all progress is discarded.
- A button held high through the release of reset is treated as a fresh 0→1 and advances once after full latency.
- Press latency: edge 1 is the first edge that samples the raw input high. MODE_INDEX, MODE_RUN and MODE_CHANGED update after edge DEBOUNCE_CYCLES+2 (edge 6 for the default).
- Repeat rate: the next press needs the release to debounce (DEBOUNCE_CYCLES+2 edges) and then a new press (another DEBOUNCE_CYCLES+2 edges).
- Timeout: forced return happens TIMEOUT_CYCLES edges after the edge that entered the non-idle mode or accepted the last press.

## Test plan
- Reset and step (NUM_MODES=4, D=4): hold reset low 3 cycles, then press SW_MODE 10 cycles, four times → MODE_INDEX 1,2,3,0 and MODE_RUN 001,010,100,000. Each change lands 6 edges after the press; one MODE_CHANGED per press.
- Glitch and hold: a 3-cycle SW_MODE pulse → no change. SW_MODE held 200 cycles → exactly one advance.
- Back wrap and collision: from mode 0, SW_BACK → mode 3. Both buttons rising together → mode stays 3, MODE_CHANGED stays 0.
- Timeout (TIMEOUT_CYCLES=20): enter mode 1 and idle → mode 0 exactly 20 edges after entry, with MODE_CHANGED and TIMEOUT_FLAG pulsing once. A press accepted on the timeout edge → mode 2 and no TIMEOUT_FLAG.
- Lock: MODE_LOCK=1 in mode 2, press SW_MODE and wait 100 cycles → mode stays 2 and no timeout. Release lock → timeout 20 edges later.
- Reset mid-operation: assert reset 2 edges before an expected advance → mode 0 and no MODE_CHANGED. A held button advances once after reset is released, 6 edges later.
